// File: rtl/serial_add_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_add_pkg
// Brief    : Shared types and constants for the bit-serial adder controller.
// Revision : 1.0
// ============================================================================
package serial_add_pkg;

  localparam int SA_DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sa_state_t;

  // Two's-complement overflow: carry into the MSB differs from carry out of it.
  function automatic logic sa_signed_ovf(input logic carry_into_msb,
                                         input logic carry_out_msb);
    return carry_into_msb ^ carry_out_msb;
  endfunction

endpackage
`default_nettype wire

// File: rtl/full_add.sv
`default_nettype none
// ============================================================================
// Module   : full_add
// Brief    : Combinational 1-bit full adder with exposed internal nodes.
// Revision : 1.0
// ============================================================================
module full_add (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic cout,
  output logic w1,
  output logic w2,
  output logic w3
);

  assign w1   = a ^ b;
  assign w2   = a & b;
  assign w3   = w1 & c;
  assign s    = w1 ^ c;
  assign cout = w2 | w3;

endmodule
`default_nettype wire

// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : serial_add_ctrl
// Brief    : LSB-first bit-serial add/subtract controller around one full_add.
// Revision : 1.0
// ============================================================================
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = SA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int                CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  sa_state_t         state_q;
  logic [WIDTH-1:0]  a_sr_q;
  logic [WIDTH-1:0]  b_sr_q;
  logic [WIDTH-1:0]  res_sr_q;
  logic              carry_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              busy_q;
  logic              done_q;
  logic [WIDTH-1:0]  sum_q;
  logic              cout_q;
  logic              ovf_q;

  logic              cell_s;
  logic              cell_cout;
  logic [WIDTH-1:0]  res_d;

  full_add u_cell (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .c    (carry_q),
    .s    (cell_s),
    .cout (cell_cout),
    .w1   (),
    .w2   (),
    .w3   ()
  );

  assign res_d = {cell_s, res_sr_q[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_sr_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            // Subtraction is a + ~b + 1: invert B and force the initial carry.
            a_sr_q  <= a_in;
            b_sr_q  <= sub ? ~b_in : b_in;
            carry_q <= sub ? 1'b1 : cin;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          res_sr_q <= res_d;
          a_sr_q   <= a_sr_q >> 1;
          b_sr_q   <= b_sr_q >> 1;
          carry_q  <= cell_cout;
          cnt_q    <= cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) begin
            // On the MSB cycle carry_q is the carry into the MSB; load results
            // now so they are visible alongside the done pulse.
            sum_q   <= res_d;
            cout_q  <= cell_cout;
            ovf_q   <= sa_signed_ovf(carry_q, cell_cout);
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule
`default_nettype wire

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Bit-serial adder/subtractor controller. It sequences one instance of the team's 1-bit full adder over WIDTH clock cycles, processing the LSB first, so a single adder cell computes a WIDTH-bit sum or difference. It uses a start/busy/done handshake toward the host logic and holds registered results until the next operation completes. This is the first sequential block built around the combinational full-adder cell.

Parameters:
WIDTH, 8, operand and result width in bits; legal values are 2..32.

Ports:
clk    input   1      single clock; all state updates on the rising edge
rst_n  input   1      asynchronous, active-low reset
start  input   1      request a new operation; sampled only in IDLE
sub    input   1      0 = add (a_in + b_in + cin); 1 = subtract (a_in - b_in); sampled with start
cin    input   1      carry-in for add; ignored when sub = 1
a_in   input   WIDTH  operand A; sampled with start
b_in   input   WIDTH  operand B; sampled with start
busy   output  1      high while an operation is in progress
done   output  1      one-cycle pulse; sum, cout and ovf are valid from this cycle
sum    output  WIDTH  registered result
cout   output  1      carry out of the MSB (for subtract, 1 = no borrow)
ovf    output  1      signed overflow = carry into MSB XOR carry out of MSB

Behaviour:
- Interface decision: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset (any time, including mid-operation):
  - state = IDLE.
  - busy, done, sum, cout, ovf, the shift registers, the carry register and the bit counter all = 0.
  - An aborted operation never produces done.
- States: IDLE, RUN, DONE. Encoding comes from the shared package.
- IDLE:
  - start = 1 latches the operands:
    - A_sr <= a_in.
    - B_sr <= sub ? ~b_in : b_in.
    - carry <= sub ? 1 : cin.
    - cnt <= 0.
  - Then go to RUN.
  - start = 0: stay in IDLE.
- RUN:
  - Combinational cell inputs are a = A_sr[0], b = B_sr[0], c = carry.
  - Each cycle:
    - res_sr <= {s, res_sr[WIDTH-1:1]}.
    - A_sr and B_sr shift right by 1.
    - carry <= cell cout.
    - cnt++.
  - When cnt == WIDTH-1 (MSB cycle), capture msb_cin <= carry, then go to DONE.
- DONE (one cycle):
  - The output registers load: sum <= res_sr, cout <= carry, ovf <= msb_cin ^ carry.
  - These loads become visible in the same cycle done is high, so the load happens on the edge leaving RUN.
  - Next state is IDLE.
- Outputs are registered:
  - busy = 1 exactly in RUN.
  - done = 1 exactly in DONE.
  - sum, cout and ovf keep their values until the next DONE.
- Latency: with start sampled in cycle 0, busy is high in cycles 1..WIDTH and done is high in cycle WIDTH+1. Throughput is one operation per WIDTH+2 cycles.
- start during RUN or DONE is ignored. There is no queuing, and operand inputs may change freely.
- Arithmetic is modulo 2^WIDTH. cnt width is $clog2(WIDTH).
- cnt == WIDTH-1 is the only RUN exit. The counter never wraps inside RUN.

Decomposition:
- Package serial_add_pkg:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} sa_state_t.
  - Constant SA_DEFAULT_WIDTH = 8.
- Sub-module: exactly one instance of the existing combinational 1-bit adder full_add (ports a, b, c, s, cout).
  - Its w1/w2/w3 internal-node ports are left unconnected.
  - All sequencing lives in serial_add_ctrl.

Test Plan (WIDTH = 8):
- Add with overflow: a_in = 0x5A, b_in = 0x3C, sub = 0, cin = 0, start pulsed in cycle 0 -> busy high in cycles 1..8; done in cycle 9 with sum = 0x96, cout = 0, ovf = 1.
- Unsigned carry out: a_in = 0xFF, b_in = 0x01, cin = 0 -> sum = 0x00, cout = 1, ovf = 0. Same operands with cin = 1 -> sum = 0x01, cout = 1.
- Subtract with borrow: sub = 1, a_in = 0x10, b_in = 0x20 -> sum = 0xF0, cout = 0, ovf = 0.
- Subtract with signed overflow: sub = 1, a_in = 0x80, b_in = 0x01 -> sum = 0x7F, cout = 1, ovf = 1.
- start ignored while busy: start with 0x01 + 0x02, then pulse start in cycle 4 with a_in = 0xAA, b_in = 0x55 -> exactly one done, in cycle 9, with sum = 0x03. Outputs hold until the next accepted start completes.
- Reset mid-operation: rst_n = 0 in cycle 5 of a RUN -> busy, done, sum, cout and ovf = 0 immediately, and no done pulse. After release, 0x7F + 0x01 gives sum = 0x80, ovf = 1 on schedule.
